// File: rtl/msrv_32_alu_pkg.sv
// Shared definitions for the MSRV32 ALU and its two-port arbiter:
// funct3 encodings, opcode width and arbiter FSM state type.
package msrv_32_alu_pkg;

    localparam int unsigned ALU_OPCODE_W = 4;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SRL  = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/msrv_32_alu.sv
// Combinational RV32 integer ALU; opcode bit 3 selects SUB over ADD and SRA over SRL.
module msrv_32_alu
    import msrv_32_alu_pkg::*;
(
    input  logic [31:0]             op_1_in,
    input  logic [31:0]             op_2_in,
    input  logic [ALU_OPCODE_W-1:0] opcode_in,
    output logic [31:0]             result_out
);

    logic [4:0] shamt;
    logic       alt;

    assign shamt = op_2_in[4:0];
    assign alt   = opcode_in[3];

    always_comb begin
        result_out = '0;
        case (opcode_in[2:0])
            FUNCT3_ADD:  result_out = alt ? (op_1_in - op_2_in) : (op_1_in + op_2_in);
            FUNCT3_SLL:  result_out = op_1_in << shamt;
            FUNCT3_SLT:  result_out = {31'b0, $signed(op_1_in) < $signed(op_2_in)};
            FUNCT3_SLTU: result_out = {31'b0, op_1_in < op_2_in};
            FUNCT3_XOR:  result_out = op_1_in ^ op_2_in;
            FUNCT3_SRL:  result_out = alt ? $unsigned($signed(op_1_in) >>> shamt)
                                          : (op_1_in >> shamt);
            FUNCT3_OR:   result_out = op_1_in | op_2_in;
            FUNCT3_AND:  result_out = op_1_in & op_2_in;
            default:     result_out = '0;
        endcase
    end

endmodule

// File: rtl/msrv_32_alu_arbiter.sv
// Two-port arbiter sharing one ALU; results are registered and held per owner
// until the owner accepts them, allowing one op per cycle when consumed promptly.
module msrv_32_alu_arbiter
    import msrv_32_alu_pkg::*;
#(
    parameter int unsigned RR_EN = 1
) (
    input  logic                    ms_riscv32_mp_clk_in,
    input  logic                    ms_riscv32_mp_rst_n_in,

    input  logic                    req0_valid_in,
    output logic                    req0_ready_out,
    input  logic [31:0]             req0_op_1_in,
    input  logic [31:0]             req0_op_2_in,
    input  logic [ALU_OPCODE_W-1:0] req0_opcode_in,
    output logic                    rsp0_valid_out,
    input  logic                    rsp0_ready_in,
    output logic [31:0]             rsp0_result_out,

    input  logic                    req1_valid_in,
    output logic                    req1_ready_out,
    input  logic [31:0]             req1_op_1_in,
    input  logic [31:0]             req1_op_2_in,
    input  logic [ALU_OPCODE_W-1:0] req1_opcode_in,
    output logic                    rsp1_valid_out,
    input  logic                    rsp1_ready_in,
    output logic [31:0]             rsp1_result_out
);

    arb_state_t              state_q, state_d;
    logic                    owner_q;
    logic                    last_q;
    logic [31:0]             result_q;

    logic                    owner_rsp_ready;
    logic                    can_grant;
    logic                    grant_sel;
    logic                    transfer;
    logic [31:0]             alu_op_1;
    logic [31:0]             alu_op_2;
    logic [ALU_OPCODE_W-1:0] alu_opcode;
    logic [31:0]             alu_result;

    msrv_32_alu u_alu (
        .op_1_in    (alu_op_1),
        .op_2_in    (alu_op_2),
        .opcode_in  (alu_opcode),
        .result_out (alu_result)
    );

    always_comb begin
        state_d         = state_q;
        owner_rsp_ready = owner_q ? rsp1_ready_in : rsp0_ready_in;
        // A held result blocks new grants until its owner consumes it.
        can_grant       = ms_riscv32_mp_rst_n_in && ((state_q == IDLE) || owner_rsp_ready);

        if (req0_valid_in && req1_valid_in) begin
            grant_sel = (RR_EN != 0) ? ~last_q : 1'b0;
        end else begin
            grant_sel = req1_valid_in;
        end

        transfer       = can_grant && (req0_valid_in || req1_valid_in);
        req0_ready_out = transfer && !grant_sel;
        req1_ready_out = transfer && grant_sel;

        alu_op_1   = grant_sel ? req1_op_1_in   : req0_op_1_in;
        alu_op_2   = grant_sel ? req1_op_2_in   : req0_op_2_in;
        alu_opcode = grant_sel ? req1_opcode_in : req0_opcode_in;

        if (transfer) begin
            state_d = HOLD;
        end else if ((state_q == HOLD) && owner_rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (transfer) begin
                owner_q  <= grant_sel;
                last_q   <= grant_sel;
                result_q <= alu_result;
            end
        end
    end

    assign rsp0_valid_out  = (state_q == HOLD) && !owner_q;
    assign rsp1_valid_out  = (state_q == HOLD) && owner_q;
    assign rsp0_result_out = owner_q ? '0 : result_q;
    assign rsp1_result_out = owner_q ? result_q : '0;

endmodule

// File: tb/tb_msrv_32_alu_arbiter.sv
// Directed plus randomized bench for msrv_32_alu_arbiter against a transaction-level model.
module tb_msrv_32_alu_arbiter;

    localparam int RR = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  o0, o1;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;

    int          nvec = 0;
    int          nerr = 0;

    // model: at most one outstanding response
    bit          m_busy;
    int          m_owner;
    int          m_last;
    logic [31:0] m_res;
    int          last_g;

    always #5 clk = ~clk;

    msrv_32_alu_arbiter #(.RR_EN(RR)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .req0_valid_in          (v0),
        .req0_ready_out         (req0_ready),
        .req0_op_1_in           (a0),
        .req0_op_2_in           (b0),
        .req0_opcode_in         (o0),
        .rsp0_valid_out         (rsp0_valid),
        .rsp0_ready_in          (rr0),
        .rsp0_result_out        (rsp0_result),
        .req1_valid_in          (v1),
        .req1_ready_out         (req1_ready),
        .req1_op_1_in           (a1),
        .req1_op_2_in           (b1),
        .req1_opcode_in         (o1),
        .rsp1_valid_out         (rsp1_valid),
        .rsp1_ready_in          (rr1),
        .rsp1_result_out        (rsp1_result)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint      sa;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        case (op % 8)
            0: return op >= 8 ? a - b : a + b;
            1: return 32'(64'(a) * (64'd1 << sh));
            2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return op >= 8 ? 32'(sa >>> sh) : a / (32'd1 << sh);
            6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check readies before the edge, advance the model, check responses after.
    task automatic step();
        int          g;
        logic [31:0] nr;
        bit          owner_acc;
        g  = -1;
        nr = '0;
        #1;
        owner_acc = (m_owner == 0) ? rr0 : rr1;
        if (rst_n && (!m_busy || owner_acc)) begin
            if (v0 && v1)  g = (RR != 0 && m_last == 0) ? 1 : 0;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        chk("ready0", req0_ready, 32'(g == 0));
        chk("ready1", req1_ready, 32'(g == 1));
        if (g == 0) nr = ref_alu(o0, a0, b0);
        if (g == 1) nr = ref_alu(o1, a1, b1);
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_last = 1;
        end else if (g >= 0) begin
            m_busy = 1; m_owner = g; m_last = g; m_res = nr;
        end else if (m_busy && owner_acc) begin
            m_busy = 0;
        end
        last_g = g;
        @(negedge clk);
        chk("rsp0_valid", rsp0_valid, 32'(m_busy && m_owner == 0));
        chk("rsp1_valid", rsp1_valid, 32'(m_busy && m_owner == 1));
        if (m_busy) begin
            chk("owner_result", (m_owner == 0) ? rsp0_result : rsp1_result, m_res);
            chk("other_result", (m_owner == 0) ? rsp1_result : rsp0_result, 32'h0);
        end
    endtask

    initial begin
        m_busy = 0; m_owner = 0; m_last = 1; m_res = '0; last_g = -1;
        rst_n = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
        v0 = 1'b1; a0 = 32'd5; b0 = 32'd7; o0 = 4'b0000;
        v1 = 1'b0; a1 = '0; b1 = '0; o1 = '0;
        @(negedge clk);

        // reset held two cycles with a pending request, then first op
        step();
        step();
        chk("rst_rsp0_valid", rsp0_valid, 32'h0);
        chk("rst_rsp0_result", rsp0_result, 32'h0);
        rst_n = 1'b1;
        #1 chk("post_rst_ready0", req0_ready, 32'h1);
        step();
        chk("add_result", rsp0_result, 32'h0000_000C);
        v0 = 1'b0;
        step();

        // tie right after reset: port 0 first, then port 1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        v0 = 1'b1; a0 = 32'd3; b0 = 32'd5; o0 = 4'b1000;
        v1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'd1; o1 = 4'b0010;
        step();
        chk("tie_first", rsp0_result, 32'hFFFF_FFFE);
        v0 = 1'b0;
        step();
        chk("tie_second", rsp1_result, 32'h0000_0001);
        v1 = 1'b0;
        step();

        // backpressure on port 1 while port 0 waits
        v1 = 1'b1; a1 = 32'h8000_0000; b1 = 32'd4; o1 = 4'b1101; rr1 = 1'b0;
        step();
        v1 = 1'b0;
        v0 = 1'b1; a0 = 32'd10; b0 = 32'd20; o0 = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", rsp1_result, 32'hF800_0000);
            chk("bp_ready0_low", req0_ready, 32'h0);
        end
        rr1 = 1'b1;
        #1 chk("bp_ready0_rise", req0_ready, 32'h1);
        step();

        // back-to-back on port 0
        a0 = 32'd1; b0 = 32'd31; o0 = 4'b0001;
        step();
        chk("b2b_sll", rsp0_result, 32'h8000_0000);
        a0 = 32'd1; b0 = 32'd2; o0 = 4'b0011;
        step();
        chk("b2b_sltu", rsp0_result, 32'h0000_0001);
        v0 = 1'b0;
        step();

        // reset while a result is held
        v1 = 1'b1; a1 = 32'd9; b1 = 32'd9; o1 = 4'b0100; rr1 = 1'b0;
        step();
        v1 = 1'b0;
        rst_n = 1'b0;
        step();
        chk("midhold_rst_valid", rsp1_valid, 32'h0);
        rst_n = 1'b1; rr1 = 1'b1;
        step();
        chk("midhold_after", rsp1_valid, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            if (!(v0 && last_g != 0 && $urandom_range(0, 9) != 0)) begin
                v0 = ($urandom_range(0, 2) != 0);
                a0 = rand_opnd(); b0 = rand_opnd(); o0 = 4'($urandom);
            end
            if (!(v1 && last_g != 1 && $urandom_range(0, 9) != 0)) begin
                v1 = ($urandom_range(0, 2) != 0);
                a1 = rand_opnd(); b1 = rand_opnd(); o1 = 4'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/msrv_32_alu_arbiter.md
MSRV_32_ALU_ARBITER -- requirements
Module: msrv_32_alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning: 1 = round-robin arbitration, 0 = fixed priority with port 0 highest.
REQ-002 SHALL have port ms_riscv32_mp_clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_n_in, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have, for each port p in {0,1}, req<p>_valid_in, input, 1 bit: request p valid.
REQ-005 SHALL have req<p>_ready_out, output, 1 bit: request p accepted this cycle.
REQ-006 SHALL have req<p>_op_1_in and req<p>_op_2_in, input, 32 bits each: operands for request p.
REQ-007 SHALL have req<p>_opcode_in, input, 4 bits: bit 3 is the sub/arith modifier, bits 2:0 are funct3.
REQ-008 SHALL have rsp<p>_valid_out, output, 1 bit: result available for port p.
REQ-009 SHALL have rsp<p>_ready_in, input, 1 bit: port p consumes its result.
REQ-010 SHALL have rsp<p>_result_out, output, 32 bits: result for port p.

Function
REQ-011 SHALL share one ALU instance between the two ports, with a transfer defined as req<p>_valid_in and req<p>_ready_out both high in the same cycle.
REQ-012 SHALL implement FSM states IDLE and HOLD: transfer moves to HOLD; in HOLD, rsp accept with no new transfer moves to IDLE; in HOLD, rsp accept together with a new transfer stays in HOLD.
REQ-013 SHALL grant only when the state is IDLE, or when the state is HOLD and the owner port's rsp<p>_ready_in is high in that cycle.
REQ-014 SHALL drive at most one req<p>_ready_out high per cycle, combinationally from the grant and the valids; ready SHALL be 0 for a port whose valid is low.
REQ-015 SHALL arbitrate when both ports are valid: if RR_EN=1, grant the port not granted last; if RR_EN=0, grant port 0.
REQ-016 SHALL update the last-grant pointer only on a transfer.
REQ-017 SHALL grant a lone valid requester irrespective of the pointer.
REQ-018 SHALL feed the ALU the granted port's operands and opcode in the transfer cycle.
REQ-019 SHALL register the ALU result, the owner port and rsp_valid, giving rsp<p>_valid_out high exactly 1 cycle after the transfer.
REQ-020 SHALL raise rsp<p>_valid_out only for the owner port; the other port's result_out SHALL read 0.
REQ-021 SHALL hold the result and valid stable while rsp<p>_ready_in is low, with no new grant during that time.
REQ-022 SHALL, on rsp accept plus a same-cycle transfer, show the new result next cycle with no bubble, for a sustained throughput of 1 op/cycle.
REQ-023 SHALL follow the ALU arithmetic: 32-bit wrap-around add/sub; shifts use op_2[4:0]; SLT signed; SLTU unsigned; 0 results zero-extended.
REQ-024 SHALL expect requesters to hold valid, operands and opcode stable until ready; dropping valid without a transfer SHALL cancel the request with no state change.
REQ-025 SHALL treat rsp<p>_ready_in as don't-care when rsp<p>_valid_out is low.

Reset
REQ-026 SHALL, with reset low at a clock edge, force: state IDLE; rsp0/rsp1_valid_out 0; stored result 0; owner 0; last-grant pointer 1 (port 0 wins first tie).
REQ-027 SHALL drive req0/req1_ready_out to 0 while reset is low.
REQ-028 SHALL discard any operation in flight at reset (including an unaccepted HOLD result) without emitting it.

Structure
REQ-029 SHALL place in shared package msrv_32_alu_pkg: the funct3 constants (ADD 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL 101, OR 110, AND 111), ALU opcode width 4, and the IDLE/HOLD state typedef.
REQ-030 SHALL instantiate exactly one sub-module, msrv_32_alu (combinational ALU); arbitration, FSM and output registers reside in this module.

Verification
REQ-031 SHALL cover reset: rst_n low 2 cycles with req0_valid=1 -> ready0=0, rsp0_valid=0, rsp0_result=0; after release, first-cycle ready0=1.
REQ-032 SHALL cover single op: port0 ADD, op1=5, op2=7, opcode 0000 -> next cycle rsp0_valid=1, result=0x0000000C.
REQ-033 SHALL cover a tie: both valid after reset, port0 SUB 3-5 (1000), port1 SLT 0xFFFFFFFF vs 1 (0010), rsp_ready=1 -> port0 granted first, result 0xFFFFFFFE; then port1 granted, result 0x00000001.
REQ-034 SHALL cover backpressure: port1 SRA op1=0x80000000, op2=4 (1101), rsp1_ready=0 for 3 cycles with req0 valid -> result 0xF8000000 stable, ready0=0 throughout, port0 granted the cycle rsp1_ready rises.
REQ-035 SHALL cover back-to-back: port0 alone issues SLL 1<<31 then SLTU 1<2 with rsp0_ready=1 -> results 0x80000000 and 0x00000001 on consecutive cycles.
REQ-036 SHALL cover reset mid-HOLD: reset during HOLD -> rsp valid drops next edge and the held result is never accepted.
